// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings used by the fetch master, the load/store master
// and the arbiter between them.
package ahb_pkg;

  // htrans
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // hburst
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  // hsize
  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HALF  = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;
  localparam logic [2:0] HSIZE_DWORD = 3'b011;

  // hresp
  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;
  localparam logic [1:0] HRESP_RETRY = 2'b10;
  localparam logic [1:0] HRESP_SPLIT = 2'b11;

  // True while a master is inside a burst (beats after the first one).
  function automatic logic htrans_in_burst(input logic [1:0] t);
    return (t == HTRANS_SEQ) || (t == HTRANS_BUSY);
  endfunction

endpackage

// File: rtl/ahb_arb_hold_cnt.sv
// Saturating hold counter: counts cycles the non-owning master has waited
// and flags when the owner's time slice is used up.
module ahb_arb_hold_cnt #(
  parameter int MAX_HOLD = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic expired_o
);

  localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CW-1:0] LAST = CW'(MAX_HOLD - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Clear wins over increment; stop at LAST so expiry stays asserted.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/ahb_master_arbiter.sv
// Two-master AHB-Lite arbiter: m0 = instruction fetch, m1 = load/store.
// Address phase follows the current owner, write data follows the
// data-phase owner. Optional build macro ARB_ROUND_ROBIN_EN switches
// simultaneous-request resolution from fixed m0 priority to round robin.
module ahb_master_arbiter
  import ahb_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MAX_HOLD = 16
) (
  input  logic               hclk_i,
  input  logic               hreset_i,
  input  logic [1:0]         mreq_i,
  output logic [1:0]         mgrant_o,
  input  logic [3:0]         mhtrans_i,
  input  logic [2*WIDTH-1:0] mhaddr_i,
  input  logic [1:0]         mhwrite_i,
  input  logic [5:0]         mhsize_i,
  input  logic [5:0]         mhburst_i,
  input  logic [2*WIDTH-1:0] mhwdata_i,
  input  logic               hready_i,
  input  logic [1:0]         hresp_i,
  output logic [1:0]         mhready_o,
  output logic [3:0]         mhresp_o,
  output logic [1:0]         htrans_o,
  output logic [WIDTH-1:0]   haddr_o,
  output logic               hwrite_o,
  output logic [2:0]         hsize_o,
  output logic [2:0]         hburst_o,
  output logic [WIDTH-1:0]   hwdata_o,
  output logic               hmaster_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN0 = 2'd1;
  localparam logic [1:0] ST_OWN1 = 2'd2;

  logic [1:0] state_q, state_d;
  logic       downer_q, downer_d;
  logic       owner, other;
  logic       owner_req, other_req;
  logic [1:0] owner_trans;
  logic       expired;
  logic       may_release;
  logic [1:0] both_pick;
  logic       cnt_clr, cnt_inc;

  assign owner     = (state_q == ST_OWN1);
  assign other     = ~owner;
  assign owner_req = owner ? mreq_i[1] : mreq_i[0];
  assign other_req = owner ? mreq_i[0] : mreq_i[1];
  assign owner_trans = owner ? mhtrans_i[3:2] : mhtrans_i[1:0];

  // A burst in flight pins the grant; otherwise the owner gives way when it
  // stops requesting, goes idle, or has used its slice while the other waits.
  assign may_release = !htrans_in_burst(owner_trans) &&
                       (!owner_req || (owner_trans == HTRANS_IDLE) ||
                        (expired && other_req));

`ifdef ARB_ROUND_ROBIN_EN
  logic rr_q, rr_d;

  // Pointer names the master that wins the next tie; flips away from
  // whoever was just granted.
  always_comb begin
    rr_d = rr_q;
    if (hready_i && (state_d != state_q) && (state_d != ST_IDLE)) begin
      rr_d = (state_d == ST_OWN0);
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge hclk_i) begin
    if (hreset_i) begin
      rr_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
    end
  end

  assign both_pick = rr_q ? ST_OWN1 : ST_OWN0;
`else
  assign both_pick = ST_OWN0;
`endif

  // Ownership transitions; nothing moves while the slave stretches a cycle.
  always_comb begin
    state_d = state_q;
    if (hready_i) begin
      if (state_q == ST_IDLE) begin
        case (mreq_i)
          2'b01:   state_d = ST_OWN0;
          2'b10:   state_d = ST_OWN1;
          2'b11:   state_d = both_pick;
          default: state_d = ST_IDLE;
        endcase
      end else if (may_release) begin
        if (other_req) begin
          state_d = other ? ST_OWN1 : ST_OWN0;
        end else if (!owner_req) begin
          state_d = ST_IDLE;
        end
      end
    end
  end

  // Data phase belongs to whoever owned the address phase that just completed.
  always_comb begin
    downer_d = downer_q;
    if (hready_i) begin
      downer_d = owner;
    end
  end

  // Control registers.
  always_ff @(posedge hclk_i) begin
    if (hreset_i) begin
      state_q  <= ST_IDLE;
      downer_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      downer_q <= downer_d;
    end
  end

  assign cnt_clr = hready_i && (state_d != state_q);
  assign cnt_inc = hready_i && other_req;

  ahb_arb_hold_cnt #(
    .MAX_HOLD (MAX_HOLD)
  ) u_hold_cnt (
    .clk_i     (hclk_i),
    .rst_i     (hreset_i),
    .clr_i     (cnt_clr),
    .inc_i     (cnt_inc),
    .expired_o (expired)
  );

  assign hmaster_o = owner;
  assign mgrant_o  = owner ? 2'b10 : 2'b01;

  assign htrans_o = owner_trans;
  assign haddr_o  = owner ? mhaddr_i[2*WIDTH-1:WIDTH] : mhaddr_i[WIDTH-1:0];
  assign hwrite_o = owner ? mhwrite_i[1] : mhwrite_i[0];
  assign hsize_o  = owner ? mhsize_i[5:3] : mhsize_i[2:0];
  assign hburst_o = owner ? mhburst_i[5:3] : mhburst_i[2:0];
  assign hwdata_o = downer_q ? mhwdata_i[2*WIDTH-1:WIDTH] : mhwdata_i[WIDTH-1:0];

  // Slave response goes back to both masters untouched; each qualifies it
  // with its own grant.
  assign mhready_o = {2{hready_i}};
  assign mhresp_o  = {2{hresp_i}};

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Bench for ahb_master_arbiter: vector table plus hand-written sequences for
// hold expiry, burst locking, wait-stated handover, reset and ties.
module tb_ahb_master_arbiter;
  import ahb_pkg::*;

  localparam int WIDTH    = 32;
  localparam int MAX_HOLD = 16;
  localparam logic [WIDTH-1:0] A0 = 32'hA000_0010;
  localparam logic [WIDTH-1:0] A1 = 32'hB000_0020;
  localparam logic [WIDTH-1:0] D0 = 32'h0D00_0D00;
  localparam logic [WIDTH-1:0] D1 = 32'h1D11_1D11;

  logic               hclk_i = 1'b0;
  logic               hreset_i;
  logic [1:0]         mreq_i;
  logic [1:0]         mgrant_o;
  logic [1:0]         t0, t1;
  logic [3:0]         mhtrans_i;
  logic [2*WIDTH-1:0] mhaddr_i;
  logic [1:0]         mhwrite_i;
  logic [5:0]         mhsize_i;
  logic [5:0]         mhburst_i;
  logic [2*WIDTH-1:0] mhwdata_i;
  logic               hready_i;
  logic [1:0]         hresp_i;
  logic [1:0]         mhready_o;
  logic [3:0]         mhresp_o;
  logic [1:0]         htrans_o;
  logic [WIDTH-1:0]   haddr_o;
  logic               hwrite_o;
  logic [2:0]         hsize_o;
  logic [2:0]         hburst_o;
  logic [WIDTH-1:0]   hwdata_o;
  logic               hmaster_o;

  assign mhtrans_i = {t1, t0};
  assign mhaddr_i  = {A1, A0};
  assign mhwdata_i = {D1, D0};
  assign mhsize_i  = {HSIZE_WORD, HSIZE_WORD};
  assign mhburst_i = {HBURST_INCR4, HBURST_SINGLE};

  always #5 hclk_i = ~hclk_i;

  ahb_master_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
    .hclk_i    (hclk_i),
    .hreset_i  (hreset_i),
    .mreq_i    (mreq_i),
    .mgrant_o  (mgrant_o),
    .mhtrans_i (mhtrans_i),
    .mhaddr_i  (mhaddr_i),
    .mhwrite_i (mhwrite_i),
    .mhsize_i  (mhsize_i),
    .mhburst_i (mhburst_i),
    .mhwdata_i (mhwdata_i),
    .hready_i  (hready_i),
    .hresp_i   (hresp_i),
    .mhready_o (mhready_o),
    .mhresp_o  (mhresp_o),
    .htrans_o  (htrans_o),
    .haddr_o   (haddr_o),
    .hwrite_o  (hwrite_o),
    .hsize_o   (hsize_o),
    .hburst_o  (hburst_o),
    .hwdata_o  (hwdata_o),
    .hmaster_o (hmaster_o)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [1:0] grant;
    logic       master;
    logic       wd_chk;
    logic       wd_m;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic [1:0] req;
    logic [1:0] tr0;
    logic [1:0] tr1;
    logic       rdy;
    logic [1:0] grant;
    logic       master;
  } vec_t;
  vec_t vt[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Queue the expectation, advance one edge, then compare what comes out.
  task automatic step(input logic [1:0] g, input logic m, input logic wc, input logic wm);
    exp_t e;
    e.grant = g; e.master = m; e.wd_chk = wc; e.wd_m = wm;
    sb_q.push_back(e);
    @(posedge hclk_i);
    #1;
    e = sb_q.pop_front();
    chk("mgrant", 64'(mgrant_o), 64'(e.grant));
    chk("hmaster", 64'(hmaster_o), 64'(e.master));
    chk("htrans", 64'(htrans_o), 64'(e.master ? t1 : t0));
    chk("haddr", 64'(haddr_o), 64'(e.master ? A1 : A0));
    if (e.wd_chk) chk("hwdata", 64'(hwdata_o), 64'(e.wd_m ? D1 : D0));
  endtask

  task automatic do_reset();
    hreset_i = 1'b1;
    mreq_i   = 2'b00;
    t0 = HTRANS_IDLE; t1 = HTRANS_IDLE;
    hready_i = 1'b1;
    hresp_i  = HRESP_OKAY;
    step(2'b01, 1'b0, 1'b1, 1'b0);
    chk("rst_htrans_idle", 64'(htrans_o), 64'(HTRANS_IDLE));
    hreset_i = 1'b0;
  endtask

  initial begin
    hreset_i  = 1'b1;
    mreq_i    = 2'b00;
    t0 = HTRANS_IDLE; t1 = HTRANS_IDLE;
    mhwrite_i = 2'b00;
    hready_i  = 1'b1;
    hresp_i   = HRESP_OKAY;

    //          req    tr0           tr1            rdy   grant  m
    vt[0]  = '{2'b00, HTRANS_IDLE,   HTRANS_IDLE,   1'b1, 2'b01, 1'b0};
    vt[1]  = '{2'b10, HTRANS_IDLE,   HTRANS_IDLE,   1'b0, 2'b01, 1'b0};
    vt[2]  = '{2'b10, HTRANS_IDLE,   HTRANS_IDLE,   1'b1, 2'b10, 1'b1};
    vt[3]  = '{2'b10, HTRANS_IDLE,   HTRANS_NONSEQ, 1'b1, 2'b10, 1'b1};
    vt[4]  = '{2'b00, HTRANS_IDLE,   HTRANS_NONSEQ, 1'b1, 2'b01, 1'b0};
    vt[5]  = '{2'b01, HTRANS_IDLE,   HTRANS_IDLE,   1'b1, 2'b01, 1'b0};
    vt[6]  = '{2'b11, HTRANS_NONSEQ, HTRANS_IDLE,   1'b1, 2'b01, 1'b0};
    vt[7]  = '{2'b11, HTRANS_IDLE,   HTRANS_IDLE,   1'b0, 2'b01, 1'b0};
    vt[8]  = '{2'b11, HTRANS_IDLE,   HTRANS_IDLE,   1'b1, 2'b10, 1'b1};
    vt[9]  = '{2'b11, HTRANS_IDLE,   HTRANS_NONSEQ, 1'b1, 2'b10, 1'b1};
    vt[10] = '{2'b01, HTRANS_IDLE,   HTRANS_IDLE,   1'b1, 2'b01, 1'b0};
    vt[11] = '{2'b00, HTRANS_IDLE,   HTRANS_IDLE,   1'b1, 2'b01, 1'b0};

    do_reset();
    chk("fwd_hready", 64'(mhready_o), 64'(2'b11));

    for (int i = 0; i < 12; i++) begin
      mreq_i   = vt[i].req;
      t0       = vt[i].tr0;
      t1       = vt[i].tr1;
      hready_i = vt[i].rdy;
      step(vt[i].grant, vt[i].master, 1'b0, 1'b0);
    end

    // Tie from IDLE after reset goes to m0; the next tie depends on the build.
    do_reset();
    mreq_i = 2'b11; t0 = HTRANS_NONSEQ; t1 = HTRANS_NONSEQ;
    step(2'b01, 1'b0, 1'b0, 1'b0);
    mreq_i = 2'b00; t0 = HTRANS_IDLE; t1 = HTRANS_IDLE;
    step(2'b01, 1'b0, 1'b0, 1'b0);
    mreq_i = 2'b11;
`ifdef ARB_ROUND_ROBIN_EN
    step(2'b10, 1'b1, 1'b0, 1'b0);
`else
    step(2'b01, 1'b0, 1'b0, 1'b0);
`endif

    // m0 streams singles while m1 waits: grant moves on m1's 16th waiting cycle.
    do_reset();
    mreq_i = 2'b01; t0 = HTRANS_NONSEQ;
    step(2'b01, 1'b0, 1'b0, 1'b0);
    mreq_i = 2'b11;
    for (int j = 1; j <= 16; j++) begin
      if (j == 16) step(2'b10, 1'b1, 1'b0, 1'b0);
      else         step(2'b01, 1'b0, 1'b0, 1'b0);
    end
    t1 = HTRANS_NONSEQ;
    step(2'b10, 1'b1, 1'b0, 1'b0);

    // m1 INCR4 burst (with a BUSY) straddles expiry: no split, saturated
    // counter hands over on the next NONSEQ.
    do_reset();
    mreq_i = 2'b10; t1 = HTRANS_NONSEQ;
    step(2'b10, 1'b1, 1'b0, 1'b0);
    mreq_i = 2'b11; t0 = HTRANS_NONSEQ;
    for (int c = 1; c <= 19; c++) begin
      case (c)
        15, 17, 18: t1 = HTRANS_SEQ;
        16:         t1 = HTRANS_BUSY;
        default:    t1 = HTRANS_NONSEQ;
      endcase
      if (c == 19) step(2'b01, 1'b0, 1'b0, 1'b0);
      else         step(2'b10, 1'b1, 1'b0, 1'b0);
      if (c == 17) chk("hburst_m1", 64'(hburst_o), 64'(HBURST_INCR4));
    end
    chk("hburst_m0", 64'(hburst_o), 64'(HBURST_SINGLE));

    // Handover right after an m0 write, then 3 wait states: write data stays on m0.
    do_reset();
    mhwrite_i = 2'b11;
    mreq_i = 2'b01; t0 = HTRANS_NONSEQ;
    step(2'b01, 1'b0, 1'b1, 1'b0);
    chk("hwrite", 64'(hwrite_o), 64'(1'b1));
    chk("hsize", 64'(hsize_o), 64'(HSIZE_WORD));
    mreq_i = 2'b10;
    step(2'b10, 1'b1, 1'b1, 1'b0);
    hready_i = 1'b0; t1 = HTRANS_NONSEQ;
    for (int w = 0; w < 3; w++) step(2'b10, 1'b1, 1'b1, 1'b0);
    chk("fwd_hready_low", 64'(mhready_o), 64'(2'b00));
    hready_i = 1'b1;
    step(2'b10, 1'b1, 1'b1, 1'b1);
    mhwrite_i = 2'b00;

    // ERROR response leaves the grant alone; reset mid-transfer returns to m0.
    do_reset();
    mreq_i = 2'b10; t1 = HTRANS_NONSEQ;
    step(2'b10, 1'b1, 1'b0, 1'b0);
    hresp_i = HRESP_ERROR;
    step(2'b10, 1'b1, 1'b0, 1'b0);
    chk("fwd_hresp", 64'(mhresp_o), 64'({HRESP_ERROR, HRESP_ERROR}));
    hresp_i = HRESP_OKAY;
    hreset_i = 1'b1; t1 = HTRANS_SEQ; t0 = HTRANS_IDLE;
    step(2'b01, 1'b0, 1'b1, 1'b0);
    chk("rst_mid_htrans", 64'(htrans_o), 64'(HTRANS_IDLE));
    hreset_i = 1'b0; t1 = HTRANS_NONSEQ;
    step(2'b10, 1'b1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ahb_master_arbiter.md
AHB_MASTER_ARBITER -- requirements
Module: ahb_master_arbiter

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 32, the address and data width.
REQ-002 The block SHALL have one parameter: MAX_HOLD, default 16, the cycles the owner may keep the bus while the other master waits.
REQ-003 hclk_i  in  1  the only clock; all state updates on its rising edge.
REQ-004 hreset_i  in  1  reset, synchronous and active-high.
REQ-005 mreq_i  in  2  bus request; bit0 = fetch master (m0), bit1 = load/store master (m1).
REQ-006 mgrant_o  out  2  one-hot grant; bit n goes to master n's hgrant_i.
REQ-007 mhtrans_i  in  4  htrans of each master; bits [2n+1:2n] belong to master n.
REQ-008 mhaddr_i  in  2*WIDTH  haddr of each master.
REQ-009 mhwrite_i  in  2  hwrite of each master.
REQ-010 mhsize_i, mhburst_i  in  6 each  hsize and hburst, 3 bits per master.
REQ-011 mhwdata_i  in  2*WIDTH  hwdata of each master.
REQ-012 hready_i, hresp_i  in  1, 2  slave response; forwarded unchanged to both masters.
REQ-013 htrans_o, haddr_o, hwrite_o, hsize_o, hburst_o  out  2, WIDTH, 1, 3, 3  muxed address phase.
REQ-014 hwdata_o  out  WIDTH  muxed data phase.
REQ-015 hmaster_o  out  1  index of the master that currently owns the address phase.

Function
REQ-016 The arbiter SHALL use a state machine with states IDLE (default owner m0, no request), OWN0, and OWN1.
REQ-017 Address-phase outputs SHALL be driven combinationally from the master selected by hmaster_o.
REQ-018 hwdata_o SHALL be selected by a data-phase owner register; that register loads hmaster_o when hready_i=1.
REQ-019 A handover SHALL occur only on a cycle with hready_i=1, and only when one of these holds:
  - the owner's mreq_i bit is 0, or
  - the owner's htrans is IDLE, or
  - the hold counter equals MAX_HOLD-1 and the other master is requesting.
REQ-020 mgrant_o and hmaster_o SHALL change on the clock edge that ends the handover cycle, so latency from request to grant is 1 cycle minimum.
REQ-021 While the owner's htrans is SEQ or BUSY, the arbiter SHALL NOT hand over, even if the hold counter has expired, so that bursts are never split.
REQ-022 On simultaneous requests from IDLE, the arbiter SHALL grant m0.
REQ-023 The hold counter SHALL clear on every grant change and increment while the other master is requesting.
REQ-024 The hold counter SHALL saturate at MAX_HOLD-1.
REQ-025 When no master requests, the arbiter SHALL enter IDLE with mgrant_o=2'b01, and m0 SHALL drive htrans_o.
REQ-026 hresp_i=ERROR SHALL NOT alter the grant; the current owner handles it.
REQ-027 While hready_i=0, the grant, the data-phase owner, and the counter SHALL all hold their values.

Reset
REQ-028 With hreset_i=1 at an edge, the block SHALL set state=IDLE, mgrant_o=2'b01, hmaster_o=0, data-phase owner=0, counter=0 and round-robin pointer=0.
REQ-029 A reset in the middle of a transfer SHALL abort it; htrans_o then reflects m0, which drives IDLE while in reset.

Configuration
REQ-030 When ARB_ROUND_ROBIN_EN is defined, the arbiter SHALL resolve simultaneous requests in favour of the master not served last, using a 1-bit pointer updated on each grant.
REQ-031 When ARB_ROUND_ROBIN_EN is undefined, the arbiter SHALL use fixed priority with m0 highest, and the pointer logic SHALL be absent.

Structure
REQ-032 The htrans, hburst, hsize and hresp encodings SHALL live in shared package ahb_pkg, reused by the fetch and load/store masters.
REQ-033 The arbiter state encoding SHALL be local to this block.
REQ-034 The block SHALL contain one sub-module, ahb_arb_hold_cnt, implementing the saturating hold counter.

Verification
REQ-035 The bench SHALL cover: only m1 requests from IDLE with hready_i=1 -> mgrant_o=2'b10 and hmaster_o=1 after 1 edge, and haddr_o=m1 address.
REQ-036 The bench SHALL cover: both request from IDLE -> m0 granted; with ARB_ROUND_ROBIN_EN defined, the next simultaneous contention grants m1.
REQ-037 The bench SHALL cover: m0 holds with NONSEQ singles while m1 requests, MAX_HOLD=16 -> grant moves to m1 on the 16th cycle of m1 waiting.
REQ-038 The bench SHALL cover: m1 issues an INCR4 burst while m0 requests and the counter expires mid-burst -> no handover until the burst ends.
REQ-039 The bench SHALL cover: a handover during a write with hready_i=0 for 3 cycles -> hwdata_o stays on the old owner until hready_i=1.
REQ-040 The bench SHALL cover: hreset_i asserted for 1 cycle while OWN1 -> mgrant_o=2'b01, hmaster_o=0 and htrans_o=IDLE the next cycle.
